// File: rtl/spec_pkg.sv
// Shared constants and helpers for the spectrum-analyser power stage.
package spec_pkg;

  localparam int unsigned DEFAULT_IN_W  = 32;
  localparam int unsigned DEFAULT_IDX_W = 10;
  localparam int unsigned MAGSQ_LAT     = 3;

  // Working width for abs_u; callers sign-extend into it, so IN_W must not exceed it.
  localparam int unsigned ABS_W = 64;

  // Magnitude of a signed value as unsigned; the most negative input maps to 2**(ABS_W-1).
  function automatic logic [ABS_W-1:0] abs_u(input logic signed [ABS_W-1:0] v);
    logic [ABS_W-1:0] r;
    if (v[ABS_W-1]) begin
      r = ABS_W'(-v);
    end else begin
      r = ABS_W'(v);
    end
    return r;
  endfunction

endpackage

// File: rtl/mag_sq_peak_if.sv
// Stream bundle for mag_sq_peak: complex bin in, power beat and frame peak out.
interface mag_sq_peak_if
  import spec_pkg::*;
#(
  parameter int unsigned IN_W  = DEFAULT_IN_W,
  parameter int unsigned IDX_W = DEFAULT_IDX_W
);

  localparam int unsigned OUT_W = 2 * IN_W;

  logic                    s_valid;
  logic                    s_ready;
  logic signed [IN_W-1:0]  s_real;
  logic signed [IN_W-1:0]  s_imag;
  logic                    s_last;

  logic                    m_valid;
  logic                    m_ready;
  logic        [OUT_W-1:0] m_power;
  logic        [IDX_W-1:0] m_index;
  logic                    m_last;

  logic                    pk_valid;
  logic        [OUT_W-1:0] pk_power;
  logic        [IDX_W-1:0] pk_index;

  // The power stage: consumes bins, produces power beats and peak reports.
  modport slave (
    input  s_valid, s_real, s_imag, s_last, m_ready,
    output s_ready, m_valid, m_power, m_index, m_last, pk_valid, pk_power, pk_index
  );

  // The surrounding datapath: FFT source plus display/averaging sink.
  modport master (
    output s_valid, s_real, s_imag, s_last, m_ready,
    input  s_ready, m_valid, m_power, m_index, m_last, pk_valid, pk_power, pk_index
  );

endinterface

// File: rtl/sq_peak_tracker.sv
// Running per-frame maximum of the power stream; reports the peak one cycle after the last beat.
module sq_peak_tracker #(
  parameter int unsigned OUT_W = 64,
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hs,
  input  logic [OUT_W-1:0] power,
  input  logic [IDX_W-1:0] index,
  input  logic             last,
  output logic             pk_valid,
  output logic [OUT_W-1:0] pk_power,
  output logic [IDX_W-1:0] pk_index
);

  logic             have_q, have_d;
  logic [OUT_W-1:0] run_pow_q, run_pow_d;
  logic [IDX_W-1:0] run_idx_q, run_idx_d;
  logic             pk_valid_q, pk_valid_d;
  logic [OUT_W-1:0] pk_pow_q, pk_pow_d;
  logic [IDX_W-1:0] pk_idx_q, pk_idx_d;

  logic             take;
  logic [OUT_W-1:0] cand_pow;
  logic [IDX_W-1:0] cand_idx;

  // Strict compare keeps the earlier (lower) index on ties.
  assign take     = !have_q || (power > run_pow_q);
  assign cand_pow = take ? power : run_pow_q;
  assign cand_idx = take ? index : run_idx_q;

  always_comb begin
    have_d     = have_q;
    run_pow_d  = run_pow_q;
    run_idx_d  = run_idx_q;
    pk_valid_d = 1'b0;
    pk_pow_d   = pk_pow_q;
    pk_idx_d   = pk_idx_q;
    if (hs) begin
      if (last) begin
        pk_valid_d = 1'b1;
        pk_pow_d   = cand_pow;
        pk_idx_d   = cand_idx;
        have_d     = 1'b0;
        run_pow_d  = '0;
        run_idx_d  = '0;
      end else begin
        have_d     = 1'b1;
        run_pow_d  = cand_pow;
        run_idx_d  = cand_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      have_q     <= 1'b0;
      run_pow_q  <= '0;
      run_idx_q  <= '0;
      pk_valid_q <= 1'b0;
      pk_pow_q   <= '0;
      pk_idx_q   <= '0;
    end else begin
      have_q     <= have_d;
      run_pow_q  <= run_pow_d;
      run_idx_q  <= run_idx_d;
      pk_valid_q <= pk_valid_d;
      pk_pow_q   <= pk_pow_d;
      pk_idx_q   <= pk_idx_d;
    end
  end

  assign pk_valid = pk_valid_q;
  assign pk_power = pk_pow_q;
  assign pk_index = pk_idx_q;

endmodule

// File: rtl/mag_sq_peak.sv
// FFT bin (re, im) -> |X|^2 in a 3-stage lock-step pipeline with per-frame bin index and peak report.
module mag_sq_peak
  import spec_pkg::*;
#(
  parameter int unsigned IN_W  = DEFAULT_IN_W,
  parameter int unsigned IDX_W = DEFAULT_IDX_W
) (
  input logic          clk,
  input logic          rst,
  mag_sq_peak_if.slave bus
);

  localparam int unsigned OUT_W = 2 * IN_W;

  logic advance;
  logic accept;
  logic out_hs;

  logic signed [ABS_W-1:0] re_ext;
  logic signed [ABS_W-1:0] im_ext;

  logic [MAGSQ_LAT-1:0]            vld_q, vld_d;
  logic [MAGSQ_LAT-1:0]            last_q, last_d;
  logic [MAGSQ_LAT-1:0][IDX_W-1:0] idx_q, idx_d;

  logic [IN_W-1:0]  abs_re_q, abs_re_d;
  logic [IN_W-1:0]  abs_im_q, abs_im_d;
  logic [OUT_W-1:0] sq_re_q, sq_re_d;
  logic [OUT_W-1:0] sq_im_q, sq_im_d;
  logic [OUT_W-1:0] power_q, power_d;
  logic [IDX_W-1:0] bin_q, bin_d;

  // The whole pipe moves as one; a bubble stays a bubble.
  assign advance     = !vld_q[MAGSQ_LAT-1] || bus.m_ready;
  assign bus.s_ready = advance && !rst;
  assign accept      = bus.s_valid && bus.s_ready;
  assign out_hs      = bus.m_valid && bus.m_ready;

  assign re_ext = ABS_W'(bus.s_real);
  assign im_ext = ABS_W'(bus.s_imag);

  always_comb begin
    vld_d    = vld_q;
    last_d   = last_q;
    idx_d    = idx_q;
    abs_re_d = abs_re_q;
    abs_im_d = abs_im_q;
    sq_re_d  = sq_re_q;
    sq_im_d  = sq_im_q;
    power_d  = power_q;
    if (advance) begin
      vld_d    = {vld_q[MAGSQ_LAT-2:0], accept};
      last_d   = {last_q[MAGSQ_LAT-2:0], bus.s_last && accept};
      idx_d    = {idx_q[MAGSQ_LAT-2:0], bin_q};
      abs_re_d = IN_W'(abs_u(re_ext));
      abs_im_d = IN_W'(abs_u(im_ext));
      sq_re_d  = OUT_W'(abs_re_q) * OUT_W'(abs_re_q);
      sq_im_d  = OUT_W'(abs_im_q) * OUT_W'(abs_im_q);
      // Each square is at most 2**(OUT_W-2), so the sum cannot carry out.
      power_d  = sq_re_q + sq_im_q;
    end
  end

  always_comb begin
    bin_d = bin_q;
    if (accept) begin
      bin_d = bus.s_last ? '0 : bin_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      last_q   <= '0;
      idx_q    <= '0;
      abs_re_q <= '0;
      abs_im_q <= '0;
      sq_re_q  <= '0;
      sq_im_q  <= '0;
      power_q  <= '0;
      bin_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      abs_re_q <= abs_re_d;
      abs_im_q <= abs_im_d;
      sq_re_q  <= sq_re_d;
      sq_im_q  <= sq_im_d;
      power_q  <= power_d;
      bin_q    <= bin_d;
    end
  end

  assign bus.m_valid = vld_q[MAGSQ_LAT-1];
  assign bus.m_last  = last_q[MAGSQ_LAT-1];
  assign bus.m_index = idx_q[MAGSQ_LAT-1];
  assign bus.m_power = power_q;

  sq_peak_tracker #(
    .OUT_W (OUT_W),
    .IDX_W (IDX_W)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .hs       (out_hs),
    .power    (power_q),
    .index    (idx_q[MAGSQ_LAT-1]),
    .last     (last_q[MAGSQ_LAT-1]),
    .pk_valid (bus.pk_valid),
    .pk_power (bus.pk_power),
    .pk_index (bus.pk_index)
  );

  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    bus.m_valid && !bus.m_ready |=> bus.m_valid && $stable(bus.m_power)
                                    && $stable(bus.m_index) && $stable(bus.m_last));

  a_ready_rule: assert property (@(posedge clk) disable iff (rst)
    bus.s_ready == (!bus.m_valid || bus.m_ready));

endmodule

// File: tb/tb_mag_sq_peak.sv
// Directed and randomised checks of mag_sq_peak against hand values and a small golden model.
module tb_mag_sq_peak;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mag_sq_peak_if #(.IN_W(32), .IDX_W(10)) bus ();

  mag_sq_peak #(.IN_W(32), .IDX_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] pow;
    logic [9:0]  idx;
    logic        last;
    int          acc;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] obs_pow[$];
  logic [9:0]  obs_idx[$];
  logic [63:0] pk_pow_log[$];
  logic [9:0]  pk_idx_log[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc_n    = 0;
  int          last_lat = 0;
  logic [9:0]  bin      = '0;
  logic        acc      = 1'b0;

  logic        pk_have  = 1'b0;
  logic [63:0] pk_run   = '0;
  logic [9:0]  pk_ri    = '0;
  logic        pk_due   = 1'b0;
  logic [63:0] exp_pk_pow = '0;
  logic [9:0]  exp_pk_idx = '0;
  logic [63:0] held_pow = '0;
  logic [9:0]  held_idx = '0;

  logic        prev_stall = 1'b0;
  logic [63:0] prev_pow   = '0;
  logic [9:0]  prev_idx   = '0;
  logic        prev_last  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] pow_of(input logic signed [31:0] re, input logic signed [31:0] im);
    longint      r;
    longint      i;
    logic [63:0] a;
    logic [63:0] b;
    r = longint'(re);
    i = longint'(im);
    a = (r < 0) ? 64'(-r) : 64'(r);
    b = (i < 0) ? 64'(-i) : 64'(i);
    return a * a + b * b;
  endfunction

  task automatic clear_logs();
    obs_pow.delete();
    obs_idx.delete();
    pk_pow_log.delete();
    pk_idx_log.delete();
  endtask

  // One clock: drive at negedge, sample 1ns later, score the handshakes of the coming edge.
  task automatic cyc(input logic sv, input logic signed [31:0] re, input logic signed [31:0] im,
                     input logic last, input logic mr);
    beat_t b;
    @(negedge clk);
    bus.s_valid = sv;
    bus.s_real  = re;
    bus.s_imag  = im;
    bus.s_last  = last;
    bus.m_ready = mr;
    #1;
    cyc_n++;
    check("pk_valid", {63'd0, bus.pk_valid}, {63'd0, pk_due});
    if (bus.pk_valid) begin
      pk_pow_log.push_back(bus.pk_power);
      pk_idx_log.push_back(bus.pk_index);
    end
    if (pk_due) begin
      check("pk_power", bus.pk_power, exp_pk_pow);
      check("pk_index", 64'(bus.pk_index), 64'(exp_pk_idx));
      held_pow = exp_pk_pow;
      held_idx = exp_pk_idx;
    end else begin
      check("pk_hold", bus.pk_power, held_pow);
    end
    pk_due = 1'b0;
    if (prev_stall) begin
      check("hold_valid", {63'd0, bus.m_valid}, 64'd1);
      check("hold_power", bus.m_power, prev_pow);
      check("hold_index", 64'(bus.m_index), 64'(prev_idx));
      check("hold_last", {63'd0, bus.m_last}, {63'd0, prev_last});
    end
    check("s_ready", {63'd0, bus.s_ready}, {63'd0, (!bus.m_valid || mr)});
    if (bus.m_valid && mr) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(bus.m_index), 64'hdead);
      end else begin
        b = exp_q.pop_front();
        check("m_power", bus.m_power, b.pow);
        check("m_index", 64'(bus.m_index), 64'(b.idx));
        check("m_last", {63'd0, bus.m_last}, {63'd0, b.last});
        last_lat = cyc_n - b.acc;
        obs_pow.push_back(bus.m_power);
        obs_idx.push_back(bus.m_index);
        if (!pk_have || b.pow > pk_run) begin
          pk_run = b.pow;
          pk_ri  = b.idx;
        end
        pk_have = 1'b1;
        if (b.last) begin
          exp_pk_pow = pk_run;
          exp_pk_idx = pk_ri;
          pk_due     = 1'b1;
          pk_have    = 1'b0;
        end
      end
    end
    prev_stall = bus.m_valid && !mr;
    prev_pow   = bus.m_power;
    prev_idx   = bus.m_index;
    prev_last  = bus.m_last;
    acc = sv && bus.s_ready;
    if (acc) begin
      b.pow  = pow_of(re, im);
      b.idx  = bin;
      b.last = last;
      b.acc  = cyc_n;
      exp_q.push_back(b);
      bin = last ? 10'd0 : bin + 10'd1;
    end
  endtask

  task automatic send(input logic signed [31:0] re, input logic signed [31:0] im, input logic last);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      cyc(1'b1, re, im, last, 1'b1);
      done = acc;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_q.size() != 0 || pk_due); i++) begin
      cyc(1'b0, 32'sd0, 32'sd0, 1'b0, 1'b1);
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_m_valid", {63'd0, bus.m_valid}, 64'd0);
    check("rst_m_power", bus.m_power, 64'd0);
    check("rst_m_index", 64'(bus.m_index), 64'd0);
    check("rst_m_last", {63'd0, bus.m_last}, 64'd0);
    check("rst_pk_valid", {63'd0, bus.pk_valid}, 64'd0);
    check("rst_pk_power", bus.pk_power, 64'd0);
    check("rst_pk_index", 64'(bus.pk_index), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_s_ready", {63'd0, bus.s_ready}, 64'd1);
    exp_q.delete();
    bin        = '0;
    pk_have    = 1'b0;
    pk_due     = 1'b0;
    held_pow   = '0;
    held_idx   = '0;
    prev_stall = 1'b0;
  endtask

  initial begin
    int n_acc;
    logic sv;
    logic mr;
    bus.s_valid = 1'b0;
    bus.s_real  = '0;
    bus.s_imag  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;

    // Single sample, latency and single-bin frame.
    do_reset();
    clear_logs();
    send(32'sd3, -32'sd4, 1'b1);
    drain();
    check("t1_count", 64'(obs_pow.size()), 64'd1);
    if (obs_pow.size() == 1) begin
      check("t1_power", obs_pow[0], 64'd25);
      check("t1_index", 64'(obs_idx[0]), 64'd0);
    end
    check("t1_latency", 64'(last_lat), 64'd3);
    check("t1_pk_count", 64'(pk_pow_log.size()), 64'd1);
    if (pk_pow_log.size() == 1) begin
      check("t1_pk_power", pk_pow_log[0], 64'd25);
      check("t1_pk_index", 64'(pk_idx_log[0]), 64'd0);
    end

    // Arithmetic extremes.
    clear_logs();
    send(32'sh8000_0000, 32'sh8000_0000, 1'b0);
    send(32'sd0, 32'sd0, 1'b1);
    drain();
    check("t2_count", 64'(obs_pow.size()), 64'd2);
    if (obs_pow.size() == 2) begin
      check("t2_max_power", obs_pow[0], 64'h8000_0000_0000_0000);
      check("t2_zero_power", obs_pow[1], 64'd0);
    end
    if (pk_pow_log.size() == 1) begin
      check("t2_pk_power", pk_pow_log[0], 64'h8000_0000_0000_0000);
      check("t2_pk_index", 64'(pk_idx_log[0]), 64'd0);
    end else check("t2_pk_count", 64'(pk_pow_log.size()), 64'd1);

    // Backpressure: 8 bins, m_ready low in cycles 4..7.
    clear_logs();
    n_acc = 0;
    for (int c = 0; c < 40 && n_acc < 8; c++) begin
      mr = !(c >= 4 && c <= 7);
      cyc(1'b1, 32'(n_acc + 1), 32'sd0, n_acc == 7, mr);
      if (c >= 4 && c <= 7) check("t3_stall_s_ready", {63'd0, bus.s_ready}, 64'd0);
      if (acc) n_acc++;
    end
    drain();
    check("t3_count", 64'(obs_idx.size()), 64'd8);
    for (int i = 0; i < obs_idx.size(); i++) begin
      check("t3_order", 64'(obs_idx[i]), 64'(i));
      check("t3_power", obs_pow[i], 64'((i + 1) * (i + 1)));
    end

    // Peak tie {5, 9, 9, 1} then a fresh single-bin frame {2}.
    clear_logs();
    send(32'sd1, 32'sd2, 1'b0);
    send(32'sd3, 32'sd0, 1'b0);
    send(32'sd0, -32'sd3, 1'b0);
    send(32'sd1, 32'sd0, 1'b1);
    send(-32'sd1, 32'sd1, 1'b1);
    drain();
    check("t4_pk_count", 64'(pk_pow_log.size()), 64'd2);
    if (pk_pow_log.size() == 2) begin
      check("t4_pk_power", pk_pow_log[0], 64'd9);
      check("t4_pk_index", 64'(pk_idx_log[0]), 64'd1);
      check("t4_next_power", pk_pow_log[1], 64'd2);
      check("t4_next_index", 64'(pk_idx_log[1]), 64'd0);
    end

    // Reset in the middle of a frame.
    clear_logs();
    send(32'sd7, 32'sd7, 1'b0);
    send(32'sd8, 32'sd8, 1'b0);
    send(32'sd9, 32'sd9, 1'b0);
    cyc(1'b0, 32'sd0, 32'sd0, 1'b0, 1'b1);
    do_reset();
    clear_logs();
    send(32'sd5, 32'sd0, 1'b1);
    drain();
    check("t5_count", 64'(obs_idx.size()), 64'd1);
    if (obs_idx.size() == 1) begin
      check("t5_index", 64'(obs_idx[0]), 64'd0);
      check("t5_power", obs_pow[0], 64'd25);
    end
    if (pk_pow_log.size() == 1) begin
      check("t5_pk_power", pk_pow_log[0], 64'd25);
      check("t5_pk_index", 64'(pk_idx_log[0]), 64'd0);
    end else check("t5_pk_count", 64'(pk_pow_log.size()), 64'd1);

    // Random stream with random backpressure.
    clear_logs();
    n_acc = 0;
    for (int c = 0; c < 6000 && n_acc < 1000; c++) begin
      sv = ($urandom_range(0, 9) != 0);
      mr = ($urandom_range(0, 3) != 0);
      cyc(sv, $urandom, $urandom, (n_acc == 999) || ($urandom_range(0, 7) == 0), mr);
      if (acc) n_acc++;
    end
    check("t6_accepted", 64'(n_acc), 64'd1000);
    drain();
    check("t6_out_count", 64'(obs_pow.size()), 64'd1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
